// File: rtl/inst_bus_arbiter_pkg.sv
// ============================================================================
// Module      : Types (package)
// Description : Instruction-side bus types shared by the arbiter, its owner
//               FIFO and the bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package Types;

    typedef logic [31:0] InstAddr;
    typedef logic [31:0] Inst;

    // Identity of the master that owns an outstanding read
    typedef logic InstArbOwner;

    localparam InstArbOwner IARB_M0 = 1'b0;
    localparam InstArbOwner IARB_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/inst_bus_arbiter_if.sv
// ============================================================================
// Module      : inst_bus_arbiter_if
// Description : Bundles both instruction masters and the memory port seen by
//               the arbiter. The slave modport is the arbiter's view; the
//               master modport is the view of the masters and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_bus_arbiter_if;
    import Types::*;

    logic    i_m0_req;
    InstAddr i_m0_addr;
    logic    o_m0_gnt;
    logic    o_m0_rvalid;
    Inst     o_m0_rdata;

    logic    i_m1_req;
    InstAddr i_m1_addr;
    logic    o_m1_gnt;
    logic    o_m1_rvalid;
    Inst     o_m1_rdata;

    logic    o_mem_req;
    InstAddr o_mem_addr;
    logic    i_mem_gnt;
    logic    i_mem_rvalid;
    Inst     i_mem_rdata;

    modport slave (
        input  i_m0_req, i_m0_addr,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        input  i_m1_req, i_m1_addr,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        output o_mem_req, o_mem_addr,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );

    modport master (
        output i_m0_req, i_m0_addr,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        output i_m1_req, i_m1_addr,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        input  o_mem_req, o_mem_addr,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/inst_bus_arbiter_owner_fifo.sv
// ============================================================================
// Module      : inst_arb_owner_fifo
// Description : In-order FIFO of owner IDs for outstanding reads. Register
//               array with wrapping pointers; pushes while full and pops
//               while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_arb_owner_fifo
    import Types::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                         i_clock,
    input  wire logic                         i_reset,
    input  wire logic                         i_push,
    input  wire logic                         i_pop,
    input  wire InstArbOwner                  i_din,
    output InstArbOwner                       o_head,
    output logic [$clog2(DEPTH+1)-1:0]        o_count,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    InstArbOwner       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage write, pointer advance with wrap, and occupancy tracking
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= IARB_M0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_bus_arbiter.sv
// ============================================================================
// Module      : inst_bus_arbiter
// Description : Shares one instruction memory port between the fetch stage
//               (master 0) and the debug/boot loader (master 1). Grants are
//               pass-through combinational; read responses are steered to
//               their issuer using an in-order owner FIFO.
//               Build option RV_IARB_ROUNDROBIN_EN: round-robin on ties
//               (otherwise master 0 has fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_bus_arbiter
    import Types::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic          i_clock,
    input  wire logic          i_reset,
    inst_bus_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    InstArbOwner       w_sel;
    InstArbOwner       w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rsp_ok;
    InstArbOwner       r_last;

    // Pick the master that drives the memory address this cycle
    always_comb begin
        w_sel = IARB_M0;
        if (bus.i_m0_req && bus.i_m1_req) begin
`ifdef RV_IARB_ROUNDROBIN_EN
            w_sel = ~r_last;
`else
            w_sel = IARB_M0;
`endif
        end else if (bus.i_m1_req) begin
            w_sel = IARB_M1;
        end
    end

`ifndef RV_IARB_ROUNDROBIN_EN
    // Fixed priority keeps the round-robin history but never consults it
    logic w_unused_last;
    assign w_unused_last = r_last;
`endif

    // Full blocks issue even when a pop lands in the same cycle
    assign bus.o_mem_req  = (bus.i_m0_req | bus.i_m1_req) & ~w_full;
    assign bus.o_mem_addr = (w_sel == IARB_M1) ? bus.i_m1_addr : bus.i_m0_addr;
    assign w_push         = bus.o_mem_req & bus.i_mem_gnt;
    assign bus.o_m0_gnt   = w_push & (w_sel == IARB_M0);
    assign bus.o_m1_gnt   = w_push & (w_sel == IARB_M1);

    // Responses with nothing outstanding are stale and are dropped
    assign w_pop          = bus.i_mem_rvalid & ~w_empty;
    assign w_rsp_ok       = bus.i_mem_rvalid & (w_count != '0);
    assign bus.o_m0_rvalid = w_rsp_ok & (w_head == IARB_M0);
    assign bus.o_m1_rvalid = w_rsp_ok & (w_head == IARB_M1);
    assign bus.o_m0_rdata  = bus.i_mem_rdata;
    assign bus.o_m1_rdata  = bus.i_mem_rdata;

    // Remember the most recently granted master for tie breaking
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last <= IARB_M1;
        end else if (w_push) begin
            r_last <= w_sel;
        end
    end

    inst_arb_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_sel),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

`default_nettype wire
